// File: rtl/video_cfg_master.sv
// Writes a video mode descriptor as a fixed register burst, then runs the sync request/ack handshake.
// Define VIDEO_CFG_WAIT_FLYBACK_EN to wait for a flyback rising edge before requesting sync.
module video_cfg_master #(
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int TO_W           = 21
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [10:0] m_res_x,
  input  logic        m_double_x,
  input  logic [10:0] m_hs_fp,
  input  logic [10:0] m_hs_width,
  input  logic [10:0] m_hs_bp,
  input  logic [10:0] m_res_y,
  input  logic        m_double_y,
  input  logic [10:0] m_vs_fp,
  input  logic [10:0] m_vs_width,
  input  logic [10:0] m_vs_bp,
  input  logic [7:0]  m_wpl_m1,
  input  logic        m_hires,
  input  logic [2:0]  m_bpp,
  input  logic [10:0] m_cursor_x_offset,
  input  logic        m_tregs_ack,
  output logic [5:0]  reg_addr,
  output logic [31:0] reg_wdata,
  output logic        reg_wstrobe,
  input  logic [31:0] reg_rdata,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam logic [5:0] CTRL_ADDR = 6'h20;

  typedef enum logic [3:0] {
    IDLE, WR, SYNC_SET, WAIT_HI, SYNC_CLR, WAIT_LO, FIN, ERR
`ifdef VIDEO_CFG_WAIT_FLYBACK_EN
    , WAIT_FB
`endif
  } state_t;

  state_t state_q, state_d;
  logic [3:0]    idx_q;
  logic [TO_W-1:0] cnt_q;
  logic          first_q;
  logic          error_q;
  logic          waiting;
  logic          timed_out;
  logic [31:0]   wr_data;

  logic [10:0] sh_res_x, sh_hs_fp, sh_hs_width, sh_hs_bp;
  logic [10:0] sh_res_y, sh_vs_fp, sh_vs_width, sh_vs_bp, sh_cursor;
  logic        sh_double_x, sh_double_y, sh_hires, sh_tregs_ack;
  logic [7:0]  sh_wpl_m1;
  logic [2:0]  sh_bpp;

`ifdef VIDEO_CFG_WAIT_FLYBACK_EN
  logic fb_prev_q;
  logic rdata_unused;
  assign rdata_unused = ^{reg_rdata[31:5], reg_rdata[3:2], reg_rdata[0]};
`else
  logic rdata_unused;
  assign rdata_unused = ^{reg_rdata[31:2], reg_rdata[0]};
`endif

  assign error     = error_q;
  assign timed_out = (cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    wr_data = '0;
    case (idx_q)
      4'd0:    wr_data = {sh_double_x, 20'h0, sh_res_x};
      4'd1:    wr_data = {21'h0, sh_hs_fp};
      4'd2:    wr_data = {21'h0, sh_hs_width};
      4'd3:    wr_data = {21'h0, sh_hs_bp};
      4'd4:    wr_data = {sh_double_y, 20'h0, sh_res_y};
      4'd5:    wr_data = {21'h0, sh_vs_fp};
      4'd6:    wr_data = {21'h0, sh_vs_width};
      4'd7:    wr_data = {21'h0, sh_vs_bp};
      4'd9:    wr_data = {24'h0, sh_wpl_m1};
      4'd10:   wr_data = {sh_hires, sh_bpp, 17'h0, sh_cursor};
      default: wr_data = '0;
    endcase
  end

  // The first poll cycle after entering a wait state is discarded: reg_rdata lags reg_addr by one cycle.
  always_comb begin
    state_d     = state_q;
    reg_addr    = '0;
    reg_wdata   = '0;
    reg_wstrobe = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    waiting     = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = WR;
      WR: begin
        busy        = 1'b1;
        reg_wstrobe = 1'b1;
        reg_addr    = {idx_q, 2'b00};
        reg_wdata   = wr_data;
`ifdef VIDEO_CFG_WAIT_FLYBACK_EN
        if (idx_q == 4'd10) state_d = WAIT_FB;
`else
        if (idx_q == 4'd10) state_d = SYNC_SET;
`endif
      end
`ifdef VIDEO_CFG_WAIT_FLYBACK_EN
      WAIT_FB: begin
        busy     = 1'b1;
        waiting  = 1'b1;
        reg_addr = CTRL_ADDR;
        if (!first_q && reg_rdata[4] && !fb_prev_q) state_d = SYNC_SET;
        else if (timed_out)                         state_d = ERR;
      end
`endif
      SYNC_SET: begin
        busy        = 1'b1;
        reg_wstrobe = 1'b1;
        reg_addr    = CTRL_ADDR;
        reg_wdata   = {29'h0, sh_tregs_ack, 2'b01};
        state_d     = WAIT_HI;
      end
      WAIT_HI: begin
        busy     = 1'b1;
        waiting  = 1'b1;
        reg_addr = CTRL_ADDR;
        if (!first_q && reg_rdata[1]) state_d = SYNC_CLR;
        else if (timed_out)           state_d = ERR;
      end
      SYNC_CLR: begin
        busy        = 1'b1;
        reg_wstrobe = 1'b1;
        reg_addr    = CTRL_ADDR;
        reg_wdata   = {29'h0, sh_tregs_ack, 2'b00};
        state_d     = WAIT_LO;
      end
      WAIT_LO: begin
        busy     = 1'b1;
        waiting  = 1'b1;
        reg_addr = CTRL_ADDR;
        if (!first_q && !reg_rdata[1]) state_d = FIN;
        else if (timed_out)            state_d = ERR;
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      ERR: begin
        busy        = 1'b1;
        reg_wstrobe = 1'b1;
        reg_addr    = CTRL_ADDR;
        reg_wdata   = {29'h0, sh_tregs_ack, 2'b00};
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      first_q      <= 1'b1;
      error_q      <= 1'b0;
      sh_res_x     <= '0;
      sh_double_x  <= 1'b0;
      sh_hs_fp     <= '0;
      sh_hs_width  <= '0;
      sh_hs_bp     <= '0;
      sh_res_y     <= '0;
      sh_double_y  <= 1'b0;
      sh_vs_fp     <= '0;
      sh_vs_width  <= '0;
      sh_vs_bp     <= '0;
      sh_wpl_m1    <= '0;
      sh_hires     <= 1'b0;
      sh_bpp       <= '0;
      sh_cursor    <= '0;
      sh_tregs_ack <= 1'b0;
`ifdef VIDEO_CFG_WAIT_FLYBACK_EN
      fb_prev_q    <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      first_q <= (state_d != state_q);
      if (state_d != state_q) cnt_q <= '0;
      else if (waiting)       cnt_q <= cnt_q + 1'b1;
`ifdef VIDEO_CFG_WAIT_FLYBACK_EN
      // Treat the discarded first sample as high so a level already high is not mistaken for an edge.
      fb_prev_q <= first_q ? 1'b1 : reg_rdata[4];
`endif
      if (state_q == IDLE && start) begin
        idx_q        <= '0;
        error_q      <= 1'b0;
        sh_res_x     <= m_res_x;
        sh_double_x  <= m_double_x;
        sh_hs_fp     <= m_hs_fp;
        sh_hs_width  <= m_hs_width;
        sh_hs_bp     <= m_hs_bp;
        sh_res_y     <= m_res_y;
        sh_double_y  <= m_double_y;
        sh_vs_fp     <= m_vs_fp;
        sh_vs_width  <= m_vs_width;
        sh_vs_bp     <= m_vs_bp;
        sh_wpl_m1    <= m_wpl_m1;
        sh_hires     <= m_hires;
        sh_bpp       <= m_bpp;
        sh_cursor    <= m_cursor_x_offset;
        sh_tregs_ack <= m_tregs_ack;
      end
      if (state_q == WR) idx_q <= (idx_q == 4'd7) ? 4'd9 : idx_q + 4'd1;
      if (state_q == ERR) error_q <= 1'b1;
    end
  end

endmodule
